// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wr_arbiter
//  Purpose  : Shares the register file's single write port between the
//             in-order write-back stage (WB) and a long-latency unit (LU).
//             WB has fixed priority. A starvation counter forces an LU grant,
//             stalling WB, once LU has been refused STARVE_MAX cycles in a row.
//             Write-port outputs are registered (1-cycle latency).
//  Optional : REGFILE_WR_SCOREBOARD_EN adds a REG_NUM-bit busy scoreboard
//             (set at LU issue, cleared on LU write transfer) with two
//             lookup ports.
//  Ports    : clk, rst (async, active-high)
//             i_wb_valid/o_wb_ready/i_wb_addr/i_wb_data  WB request
//             i_lu_valid/o_lu_ready/i_lu_addr/i_lu_data  LU request
//             o_stall_req                                WB refused
//             o_we/o_waddr/o_wdata                       regfile write port
//             [scoreboard] i_sb_alloc, i_sb_addr, i_chk_addr1, i_chk_addr2,
//                          o_busy1, o_busy2
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int REG_NUM    = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
`ifdef REGFILE_WR_SCOREBOARD_EN
    input  logic              i_sb_alloc,
    input  logic [ADDR_W-1:0] i_sb_addr,
    input  logic [ADDR_W-1:0] i_chk_addr1,
    input  logic [ADDR_W-1:0] i_chk_addr2,
    output logic              o_busy1,
    output logic              o_busy2,
`endif
    input  logic              i_wb_valid,
    output logic              o_wb_ready,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_lu_valid,
    output logic              o_lu_ready,
    input  logic [ADDR_W-1:0] i_lu_addr,
    input  logic [DATA_W-1:0] i_lu_data,
    output logic              o_stall_req,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata
);

    localparam int               c_CNT_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE = c_CNT_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;

    logic w_starve;
    logic w_wb_ready;
    logic w_lu_ready;
    logic w_wb_xfer;
    logic w_lu_xfer;

    // Readys depend only on the other side's valid and the counter, so they
    // never form a loop through the requester's own handshake.
    assign w_starve   = (r_cnt == c_STARVE);
    assign w_wb_ready = ~(i_lu_valid & w_starve);
    assign w_lu_ready = ~i_wb_valid | w_starve;
    assign w_wb_xfer  = i_wb_valid & w_wb_ready;
    assign w_lu_xfer  = i_lu_valid & w_lu_ready;

    assign o_wb_ready  = w_wb_ready;
    assign o_lu_ready  = w_lu_ready;
    assign o_stall_req = i_wb_valid & ~w_wb_ready;

    // Counts consecutive refused LU cycles; any cycle LU is not being
    // refused (accepted or idle) restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_lu_valid & ~w_lu_ready) begin
            if (r_cnt != c_STARVE) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Write-port register. Transfers to x0 are accepted but never written,
    // and waddr/wdata keep their previous contents whenever we is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_wb_xfer && (i_wb_addr != '0)) begin
                r_we    <= 1'b1;
                r_waddr <= i_wb_addr;
                r_wdata <= i_wb_data;
            end else if (w_lu_xfer && (i_lu_addr != '0)) begin
                r_we    <= 1'b1;
                r_waddr <= i_lu_addr;
                r_wdata <= i_lu_data;
            end
        end
    end

    assign o_we    = r_we;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;

`ifdef REGFILE_WR_SCOREBOARD_EN
    logic [REG_NUM-1:0] r_busy;
    logic [REG_NUM-1:0] w_busy_nxt;
    logic               w_busy1;
    logic               w_busy2;

    // Clear is applied before set so that a same-cycle allocate of the
    // register being written back leaves it busy for the new owner.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < REG_NUM; i++) begin
            if (w_lu_xfer && (i_lu_addr == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (i_sb_alloc && (i != 0) && (i_sb_addr == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Lookups read the registered vector only; addresses beyond REG_NUM read 0.
    always_comb begin
        w_busy1 = 1'b0;
        w_busy2 = 1'b0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (i_chk_addr1 == ADDR_W'(i)) begin
                w_busy1 = r_busy[i];
            end
            if (i_chk_addr2 == ADDR_W'(i)) begin
                w_busy2 = r_busy[i];
            end
        end
    end

    assign o_busy1 = w_busy1;
    assign o_busy2 = w_busy2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wr_arbiter
//  Purpose  : Randomized bench for regfile_wr_arbiter. A requester model
//             issues WB/LU writes and holds them until accepted; a reference
//             model predicts readys and pushes the expected write-port value
//             of the next cycle into a queue, which a separate monitor pops
//             and compares every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RN = 32;
    localparam int SM = 3;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid, lu_valid;
    logic          wb_ready, lu_ready, stall_req;
    logic [AW-1:0] wb_addr, lu_addr, waddr;
    logic [DW-1:0] wb_data, lu_data, wdata;
    logic          we;
`ifdef REGFILE_WR_SCOREBOARD_EN
    logic          sb_alloc;
    logic [AW-1:0] sb_addr, chk_addr1, chk_addr2;
    logic          busy1, busy2;
    bit            m_busy [RN];
`endif

    int checks = 0;
    int errors = 0;

    exp_t q[$];

    // requester and reference state
    bit            wb_pend, lu_pend;
    logic [AW-1:0] wb_a, lu_a;
    logic [DW-1:0] wb_d, lu_d;
    int            m_wait;
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .REG_NUM(RN), .STARVE_MAX(SM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef REGFILE_WR_SCOREBOARD_EN
        .i_sb_alloc (sb_alloc),
        .i_sb_addr  (sb_addr),
        .i_chk_addr1(chk_addr1),
        .i_chk_addr2(chk_addr2),
        .o_busy1    (busy1),
        .o_busy2    (busy2),
`endif
        .i_wb_valid (wb_valid),
        .o_wb_ready (wb_ready),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_data),
        .i_lu_valid (lu_valid),
        .o_lu_ready (lu_ready),
        .i_lu_addr  (lu_addr),
        .i_lu_data  (lu_data),
        .o_stall_req(stall_req),
        .o_we       (we),
        .o_waddr    (waddr),
        .o_wdata    (wdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait  = 0;
        hold_a  = '0;
        hold_d  = '0;
        wb_pend = 0;
        lu_pend = 0;
        q.delete();
`ifdef REGFILE_WR_SCOREBOARD_EN
        for (int i = 0; i < RN; i++) m_busy[i] = 0;
`endif
    endtask

    task automatic new_reqs(input int pw, input int pl);
        if (!wb_pend && ($urandom_range(0, 99) < pw)) begin
            wb_pend = 1;
            wb_a    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            wb_d    = $urandom;
        end
        if (!lu_pend && ($urandom_range(0, 99) < pl)) begin
            lu_pend = 1;
            lu_a    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            lu_d    = $urandom;
        end
    endtask

    // One clock cycle: drive at negedge, predict and check readys, push the
    // expected write-port state for after the next rising edge.
    task automatic do_cycle();
        bit   starve, exp_wr, exp_lr, wg, lg;
        exp_t e;
        @(negedge clk);
        wb_valid = wb_pend; wb_addr = wb_a; wb_data = wb_d;
        lu_valid = lu_pend; lu_addr = lu_a; lu_data = lu_d;
`ifdef REGFILE_WR_SCOREBOARD_EN
        sb_alloc  = ($urandom_range(0, 3) == 0);
        sb_addr   = ($urandom_range(0, 1) == 0) ? lu_a : AW'($urandom);
        chk_addr1 = ($urandom_range(0, 1) == 0) ? lu_a : AW'($urandom);
        chk_addr2 = AW'($urandom);
`endif
        #1;
        starve = (m_wait >= SM);
        exp_wr = !(lu_pend && starve);
        exp_lr = !wb_pend || starve;
        wg     = wb_pend && exp_wr;
        lg     = lu_pend && exp_lr && !wg;
        chk("wb_ready", wb_ready, exp_wr);
        chk("lu_ready", lu_ready, exp_lr);
        chk("stall_req", stall_req, wb_pend && !exp_wr);
`ifdef REGFILE_WR_SCOREBOARD_EN
        chk("busy1", busy1, m_busy[chk_addr1]);
        chk("busy2", busy2, m_busy[chk_addr2]);
        if (lg) m_busy[lu_a] = 0;
        if (sb_alloc && sb_addr != '0) m_busy[sb_addr] = 1;
`endif
        e.we = 0;
        if (wg && wb_a != '0) begin
            e.we = 1; hold_a = wb_a; hold_d = wb_d;
        end else if (lg && lu_a != '0) begin
            e.we = 1; hold_a = lu_a; hold_d = lu_d;
        end
        e.a = hold_a;
        e.d = hold_d;
        q.push_back(e);
        if (lu_pend && !lg) m_wait = (m_wait < SM) ? m_wait + 1 : SM;
        else                m_wait = 0;
        if (wg) wb_pend = 0;
        if (lg) lu_pend = 0;
    endtask

    // Asserts reset in the middle of a cycle; outputs must clear at once.
    task automatic reset_mid();
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        model_reset();
        wb_valid = 0; lu_valid = 0;
        @(posedge clk);
        #2 rst = 0;
    endtask

    // Monitor: compares the registered write port after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("we", we, e.we);
                    chk("waddr", waddr, e.a);
                    chk("wdata", wdata, e.d);
                end else begin
                    chk("idle_we", we, 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        wb_valid = 0; lu_valid = 0;
        wb_addr = '0; lu_addr = '0; wb_data = '0; lu_data = '0;
        wb_a = '0; lu_a = '0; wb_d = '0; lu_d = '0;
`ifdef REGFILE_WR_SCOREBOARD_EN
        sb_alloc = 0; sb_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_we", we, 0);
        chk("reset_waddr", waddr, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_wb_ready", wb_ready, 1);
        chk("reset_lu_ready", lu_ready, 1);
        chk("reset_stall", stall_req, 0);
        #2 rst = 0;

        // WB only, addr 5
        wb_pend = 1; wb_a = 5'd5; wb_d = 32'hA5A5A5A5;
        do_cycle();
        // WB to x0 must be dropped
        wb_pend = 1; wb_a = 5'd0; wb_d = 32'hFFFFFFFF;
        do_cycle();
        // LU only, addr 9
        lu_pend = 1; lu_a = 5'd9; lu_d = 32'h12345678;
        do_cycle();
        do_cycle();
        // back-to-back WB writes 1..4, then reset mid-cycle
        for (int i = 1; i <= 4; i++) begin
            wb_pend = 1; wb_a = AW'(i); wb_d = 32'h1000 + i;
            do_cycle();
        end
        reset_mid();

        // both requesters permanently valid: starvation grant pattern
        for (int i = 0; i < 24; i++) begin
            new_reqs(100, 100);
            do_cycle();
        end

        for (int i = 0; i < 300; i++) begin new_reqs(50, 50);  do_cycle(); end
        for (int i = 0; i < 300; i++) begin new_reqs(90, 90);  do_cycle(); end
        reset_mid();
        for (int i = 0; i < 300; i++) begin new_reqs(100, 30); do_cycle(); end
        for (int i = 0; i < 300; i++) begin new_reqs(20, 80);  do_cycle(); end

        // let the monitor drain the last expected entry
        @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
